coeff_bank_ctrl: RTL

COEFF_BANK_CTRL -- requirements
Module: coeff_bank_ctrl

---
 rtl/audioport_pkg.sv | 22 ++
 rtl/coeff_bank_mem.sv | 35 +++
 rtl/coeff_bank_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/audioport_pkg.sv
// Shared constants, state type and helpers for the coefficient bank controller.
package audioport_pkg;

  localparam int DEF_FILTER_TAPS = 32;
  localparam int DEF_FILTERS     = 4;
  localparam int DEF_COEFF_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    COPY
  } coeff_bank_state_t;

  function automatic int word_index(
    input int filter,
    input int tap,
    input int taps
  );
    return filter * taps + tap;
  endfunction

endpackage

// File: rtl/coeff_bank_mem.sv
// Two coefficient banks: one write port, asynchronous stream and copy read ports.
module coeff_bank_mem
  import audioport_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int AW      = 7,
  parameter int COEFF_W = 32
) (
  input  logic               clk,
  input  logic               we,
  input  logic               wbank,
  input  logic [AW-1:0]      waddr,
  input  logic [COEFF_W-1:0] wdata,
  input  logic               s_bank,
  input  logic [AW-1:0]      s_addr,
  output logic [COEFF_W-1:0] s_data,
  input  logic               c_bank,
  input  logic [AW-1:0]      c_addr,
  output logic [COEFF_W-1:0] c_data
);

  logic [COEFF_W-1:0] bank0 [DEPTH];
  logic [COEFF_W-1:0] bank1 [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      if (wbank) bank1[waddr] <= wdata;
      else       bank0[waddr] <= wdata;
    end
  end

  assign s_data = s_bank ? bank1[s_addr] : bank0[s_addr];
  assign c_data = c_bank ? bank1[c_addr] : bank0[c_addr];

endmodule

// File: rtl/coeff_bank_ctrl.sv
// Double-buffered filter coefficient store: shadow writes, atomic commit
// with bank re-sync copy, and per-filter tap streaming over valid/ready.
module coeff_bank_ctrl
  import audioport_pkg::*;
#(
  parameter int FILTER_TAPS = DEF_FILTER_TAPS,
  parameter int FILTERS     = DEF_FILTERS,
  parameter int COEFF_W     = DEF_COEFF_W,
  parameter int AW          = $clog2(FILTERS * FILTER_TAPS),
  parameter int SW          = (FILTERS > 1) ? $clog2(FILTERS) : 1,
  parameter int TW          = $clog2(FILTER_TAPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [COEFF_W-1:0] wr_data,
  input  logic               commit_req,
  input  logic               rd_start,
  input  logic [SW-1:0]      rd_sel,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [COEFF_W-1:0] rd_data,
  output logic [TW-1:0]      rd_tap,
  output logic               rd_last,
  output logic               busy,
  output logic               commit_done,
  output logic               bank_sel
);

  localparam int DEPTH = FILTERS * FILTER_TAPS;

  coeff_bank_state_t state, nstate;

  logic               take_commit;
  logic               take_stream;
  logic               copy_end;
  logic               hs;
  logic               load;
  logic               pend_rd;
  logic               pend_commit;
  logic [SW-1:0]      pend_sel;
  logic [SW-1:0]      sel;
  logic [SW-1:0]      ld_sel;
  logic [TW-1:0]      ld_tap;
  logic [AW-1:0]      s_addr;
  logic [AW-1:0]      copy_addr;
  logic [COEFF_W-1:0] s_data;
  logic [COEFF_W-1:0] c_data;
  logic               w_en;
  logic [AW-1:0]      w_addr;
  logic [COEFF_W-1:0] w_data;

  assign busy = (state != IDLE);
  assign hs   = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate      = state;
    take_commit = 1'b0;
    take_stream = 1'b0;
    copy_end    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_commit || commit_req) begin
          take_commit = 1'b1;
          nstate      = COPY;
        end else if (pend_rd || rd_start) begin
          take_stream = 1'b1;
          nstate      = STREAM;
        end
      end
      STREAM: begin
        if (hs && rd_last) nstate = IDLE;
      end
      COPY: begin
        if (copy_addr == AW'(DEPTH - 1)) begin
          copy_end = 1'b1;
          nstate   = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // Requests arriving while not IDLE (or losing to a commit) wait here.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_commit <= 1'b0;
      pend_rd     <= 1'b0;
      pend_sel    <= '0;
    end else begin
      if (take_commit)
        pend_commit <= 1'b0;
      else if (busy && commit_req)
        pend_commit <= 1'b1;
      if (take_stream)
        pend_rd <= 1'b0;
      else if (rd_start && (busy || take_commit))
        pend_rd <= 1'b1;
      if (rd_start && (busy || take_commit))
        pend_sel <= rd_sel;
    end
  end

  assign load   = take_stream || (state == STREAM && hs && !rd_last);
  assign ld_sel = take_stream ? (rd_start ? rd_sel : pend_sel) : sel;
  assign ld_tap = take_stream ? '0 : rd_tap + 1'b1;
  assign s_addr = AW'(word_index(int'(ld_sel), int'(ld_tap), FILTER_TAPS));

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_tap   <= '0;
      rd_data  <= '0;
      sel      <= '0;
    end else if (load) begin
      rd_valid <= 1'b1;
      rd_last  <= (ld_tap == TW'(FILTER_TAPS - 1));
      rd_tap   <= ld_tap;
      rd_data  <= s_data;
      sel      <= ld_sel;
    end else if (state == STREAM && hs) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel    <= 1'b0;
      copy_addr   <= '0;
      commit_done <= 1'b0;
    end else begin
      commit_done <= copy_end;
      if (take_commit) begin
        bank_sel  <= ~bank_sel;
        copy_addr <= '0;
      end else if (state == COPY) begin
        copy_addr <= copy_addr + 1'b1;
      end
    end
  end

  // The copy engine owns the write port for the whole COPY phase.
  always_comb begin
    w_en   = wr_en && (int'(wr_addr) < DEPTH);
    w_addr = wr_addr;
    w_data = wr_data;
    if (state == COPY) begin
      w_en   = !rst;
      w_addr = copy_addr;
      w_data = c_data;
    end
  end

  coeff_bank_mem #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .COEFF_W(COEFF_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_en),
    .wbank (~bank_sel),
    .waddr (w_addr),
    .wdata (w_data),
    .s_bank(bank_sel),
    .s_addr(s_addr),
    .s_data(s_data),
    .c_bank(bank_sel),
    .c_addr(copy_addr),
    .c_data(c_data)
  );

endmodule
